inst_axi_reader: RTL and testbench
==================================

// Module: inst_axi_reader
// PURPOSE
//  Responder side of the fetch request interface driven by the PC stage. Takes one
//  word-fetch request (address, read enable, cacheable flag) and turns it into a
//  single-beat AXI4 read on the AR/R channels. Returns the instruction word with a
//  one-cycle valid pulse, and holds the pipeline stalled while the bus is busy.
//  Sits between the PC stage and the AXI crossbar / instruction cache miss path.
// PARAMETERS
//  AXI_ID     4'h0   constant ARID value; RID is not checked
//  CACHED_AC  4'hF   ARCACHE value driven when req_cached_i=1
//  UNCACH_AC  4'h0   ARCACHE value driven when req_cached_i=0
// PORTS
//  clock_i        in   1   system clock, rising edge
//  reset_i        in   1   asynchronous reset, active-high
//  req_ren_i      in   1   fetch request; held with req_addr_i while stall_req_o=1
//  req_addr_i     in   32  virtual fetch address
//  req_cached_i   in   1   1=cacheable region, 0=uncached (kseg1)
//  flush_i        in   1   exception/branch flush; in-flight fetch must be dropped
//  inst_o         out  32  fetched word; holds last value between fetches
//  inst_valid_o   out  1   one-cycle pulse: inst_o is valid
//  bus_err_o      out  1   one-cycle pulse alongside inst_valid_o when RRESP[1]=1
//  stall_req_o    out  1   1 while a fetch is pending or in flight
//  araddr_o       out  32  physical word address
//  arlen_o/arsize_o/arburst_o out 8/3/2  constant 8'd0 / 3'b010 / 2'b01
//  arid_o, arcache_o out 4/4  AXI_ID; CACHED_AC or UNCACH_AC, latched with the request
//  arvalid_o      out  1   AR valid
//  arready_i      in   1   AR ready
//  rdata_i/rresp_i in  32/2  R data and response
//  rlast_i, rvalid_i in 1/1  R last and valid
//  rready_o       out  1   R ready
// BEHAVIOUR
//  Reset (async): state=IDLE. All outputs 0: inst_o, valid, err, arvalid_o, rready_o, araddr_o.
//  FSM states: IDLE, AR, R, DISCARD.
//  - IDLE: accept a request if req_ren_i=1, flush_i=0 and inst_valid_o=0.
//    On accept: latch araddr_o = {3'b000, addr[28:2], 2'b00} when addr[31:30]=2'b10
//    (kseg0/kseg1); otherwise {addr[31:2], 2'b00}. Latch arcache_o. Go to AR.
//  - AR: arvalid_o=1. Address and attributes stay stable until arready_i.
//    On arready_i: go to R, or to DISCARD if flush_i (now or earlier) was seen.
//    ARVALID is never withdrawn before the handshake, even on flush.
//  - R: rready_o=1. On rvalid_i & rlast_i: inst_o<=rdata_i; pulse inst_valid_o next
//    cycle with bus_err_o=rresp_i[1]. Go to IDLE.
//    flush_i in R, including the completion cycle: go to DISCARD, no pulse.
//  - DISCARD: rready_o=1. Swallow beats until rvalid_i & rlast_i, then go to IDLE.
//    inst_o is not updated and nothing is pulsed.
//  Flush seen in AR is remembered in a sticky flag, cleared on entry to IDLE.
//  stall_req_o = (IDLE & req_ren_i & ~flush_i & ~inst_valid_o) | (state != IDLE).
//    Combinational from state and inputs. It is 0 in the inst_valid_o cycle so the
//    consumer can advance.
//  Latency, zero wait states: request cycle -> AR -> R beat -> valid = 3 cycles.
//  Misaligned addr[1:0] is forced to 0 on the bus; the address exception is
//  flagged by the PC stage.
//  At most one outstanding read; no ID reordering.
// STRUCTURE
//  Shared package/header (defines.vh): FSM state encodings (2 bits), AXI size/burst
//  constants, kseg0/kseg1 segment masks, RST_ENABLE.
//  One natural sub-module: kseg_addr_map (combinational virt->phys map).
//  It is reused by the data-side reader.
// TESTING
//  1 Req addr 0xBFC0_0000, uncached, arready/rvalid at once -> araddr 0x1FC0_0000,
//    arcache 0, inst_valid 3 cycles after req.
//  2 Req 0x8000_0010, cached, arready held low 5 cycles -> arvalid and araddr
//    0x0000_0010 stable all 5 cycles, arcache 0xF.
//  3 Flush asserted in AR -> AR handshake still completes; R beat 0xDEADBEEF is
//    swallowed; no valid; inst_o unchanged.
//  4 Flush in the same cycle as rvalid&rlast -> no valid; state back to IDLE;
//    next request served normally.
//  5 RRESP=2'b10 on the beat -> inst_valid_o=1 and bus_err_o=1 in the same cycle.
//  6 reset_i asserted mid-R -> outputs 0 immediately (async), state IDLE,
//    stall_req_o=0 while req_ren_i=0.

Source files
------------

// File: rtl/inst_axi_reader_pkg.sv
// Shared definitions for the fetch-side AXI reader: FSM encoding, AXI read
// attribute constants and kernel-segment decode values.
package inst_axi_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_AR      = 2'd1,
    S_R       = 2'd2,
    S_DISCARD = 2'd3
  } rd_state_t;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // kseg0/kseg1 share the top two address bits; both drop bits [31:29]
  localparam logic [1:0] KSEG01_TOP     = 2'b10;

  localparam logic       RST_ENABLE     = 1'b1;

endpackage

// File: rtl/inst_axi_reader_kseg_addr_map.sv
// Combinational virtual-to-physical word address map for kseg0/kseg1;
// other segments pass through with the byte offset cleared.
module inst_axi_reader_kseg_addr_map
  import inst_axi_reader_pkg::*;
(
  input  logic [31:0] i_vaddr,
  output logic [31:0] o_paddr
);

  always_comb begin
    if (i_vaddr[31:30] == KSEG01_TOP) begin
      o_paddr = {3'b000, i_vaddr[28:2], 2'b00};
    end else begin
      o_paddr = {i_vaddr[31:2], 2'b00};
    end
  end

endmodule

// File: rtl/inst_axi_reader.sv
// Instruction fetch reader: turns one PC-stage fetch request into a single-beat
// AXI4 read and returns the word with a one-cycle valid pulse.
module inst_axi_reader
  import inst_axi_reader_pkg::*;
#(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter logic [3:0] CACHED_AC = 4'hF,
  parameter logic [3:0] UNCACH_AC = 4'h0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_ren_i,
  input  logic [31:0] req_addr_i,
  input  logic        req_cached_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        bus_err_o,
  output logic        stall_req_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [3:0]  arid_o,
  output logic [3:0]  arcache_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  rd_state_t   r_state;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_araddr;
  logic [3:0]  r_arcache;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_flushed;

  logic [31:0] w_paddr;
  logic        w_accept;
  logic        w_beat_last;
  logic        w_unused_rresp0;

  inst_axi_reader_kseg_addr_map u_addr_map (
    .i_vaddr (req_addr_i),
    .o_paddr (w_paddr)
  );

  assign w_accept        = (r_state == S_IDLE) && req_ren_i && !flush_i && !r_valid;
  assign w_beat_last     = rvalid_i && rlast_i;
  assign w_unused_rresp0 = rresp_i[0];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i == RST_ENABLE) begin
      r_state   <= S_IDLE;
      r_inst    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_araddr  <= '0;
      r_arcache <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_flushed <= 1'b0;
          if (w_accept) begin
            r_araddr  <= w_paddr;
            r_arcache <= req_cached_i ? CACHED_AC : UNCACH_AC;
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          // ARVALID must stay up until the handshake; a flush only redirects the R phase
          if (flush_i) r_flushed <= 1'b1;
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (flush_i || r_flushed) ? S_DISCARD : S_R;
          end
        end
        S_R: begin
          if (w_beat_last) begin
            r_rready  <= 1'b0;
            r_flushed <= 1'b0;
            r_state   <= S_IDLE;
            if (!flush_i) begin
              r_inst  <= rdata_i;
              r_valid <= 1'b1;
              r_err   <= rresp_i[1];
            end
          end else if (flush_i) begin
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_beat_last) begin
            r_rready  <= 1'b0;
            r_flushed <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_req_o  = w_accept || (r_state != S_IDLE);
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;
  assign bus_err_o    = r_err;
  assign araddr_o     = r_araddr;
  assign arcache_o    = r_arcache;
  assign arvalid_o    = r_arvalid;
  assign rready_o     = r_rready;
  assign arid_o       = AXI_ID;
  assign arlen_o      = AXI_LEN_SINGLE;
  assign arsize_o     = AXI_SIZE_WORD;
  assign arburst_o    = AXI_BURST_INCR;

endmodule

// File: tb/tb_inst_axi_reader.sv
// Directed bench for inst_axi_reader: stimulus pushes expected fetch results,
// a monitor pops and compares them whenever the reader pulses inst_valid_o.
module tb_inst_axi_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ren;
  logic [31:0] req_addr;
  logic        req_cached;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        bus_err;
  logic        stall;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_inst = 32'h0;

  always #5 clk = ~clk;

  inst_axi_reader dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .req_ren_i    (req_ren),
    .req_addr_i   (req_addr),
    .req_cached_i (req_cached),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .bus_err_o    (bus_err),
    .stall_req_o  (stall),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arsize_o     (arsize),
    .arburst_o    (arburst),
    .arid_o       (arid),
    .arcache_o    (arcache),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rdata_i      (rdata),
    .rresp_i      (rresp),
    .rlast_i      (rlast),
    .rvalid_i     (rvalid),
    .rready_o     (rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", inst, 32'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("inst_data", inst, e[31:0]);
        check("bus_err", {31'b0, bus_err}, {31'b0, e[32]});
      end
    end
  end

  // Full fetch; caller is 1 time unit after a rising edge with the reader idle
  task automatic do_fetch(input logic [31:0] addr, input logic cached, input int ar_wait,
                          input logic [31:0] data, input logic [1:0] resp,
                          input logic [31:0] exp_pa, input logic [3:0] exp_cache);
    req_ren = 1'b1; req_addr = addr; req_cached = cached; arready = 1'b0;
    @(negedge clk); check("stall_on_req", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      check("arvalid_wait", {31'b0, arvalid}, 32'd1);
      check("araddr_wait", araddr, exp_pa);
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(negedge clk);
    check("arvalid", {31'b0, arvalid}, 32'd1);
    check("araddr", araddr, exp_pa);
    check("arcache", {28'b0, arcache}, {28'b0, exp_cache});
    @(posedge clk); #1;
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = data; rresp = resp;
    exp_q.push_back({resp[1], data});
    last_inst = data;
    @(negedge clk); check("rready", {31'b0, rready}, 32'd1);
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    check("valid_latency", {31'b0, inst_valid}, 32'd1);
    check("stall_in_valid", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    req_ren = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_ren = 1'b0; req_addr = '0; req_cached = 1'b0; flush = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst", inst, 32'h0);
    check("rst_ctrl", {28'b0, inst_valid, arvalid, rready, stall}, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1: kseg1 uncached, zero wait states
    do_fetch(32'hBFC0_0000, 1'b0, 0, 32'h3C08_BFC0, 2'b00, 32'h1FC0_0000, 4'h0);
    check("ar_consts", {arid, 1'b0, arsize, 6'b0, arburst, arlen}, {4'h0, 1'b0, 3'b010, 6'b0, 2'b01, 8'h00});

    // 2: kseg0 cached, arready held off 5 cycles
    do_fetch(32'h8000_0010, 1'b1, 5, 32'h2402_0005, 2'b00, 32'h0000_0010, 4'hF);

    // 3: flush during AR, beat must be swallowed
    req_ren = 1'b1; req_addr = 32'h0000_1003; req_cached = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1; req_ren = 1'b0;
    @(negedge clk);
    check("flush_ar_araddr", araddr, 32'h0000_1000);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk); check("arvalid_held_after_flush", {31'b0, arvalid}, 32'd1);
    @(posedge clk); #1; arready = 1'b1;
    @(posedge clk); #1; arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    @(negedge clk);
    check("discard_rready", {31'b0, rready}, 32'd1);
    check("discard_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1; rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    check("discard_no_valid", {31'b0, inst_valid}, 32'd0);
    check("discard_inst_kept", inst, last_inst);
    check("discard_idle", {31'b0, stall}, 32'd0);

    // 4: flush coincides with the completing beat
    req_ren = 1'b1; req_addr = 32'h0040_0020; req_cached = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; arready = 1'b0; req_ren = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678; flush = 1'b1;
    @(posedge clk); #1; rvalid = 1'b0; rlast = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flushbeat_no_valid", {31'b0, inst_valid}, 32'd0);
    check("flushbeat_idle", {31'b0, stall}, 32'd0);
    check("flushbeat_inst_kept", inst, last_inst);
    @(posedge clk); #1;
    do_fetch(32'h0040_0024, 1'b0, 0, 32'hAAAA_5555, 2'b00, 32'h0040_0024, 4'h0);

    // 5: slave error response
    do_fetch(32'hA000_0100, 1'b0, 1, 32'h0BAD_0BAD, 2'b10, 32'h0000_0100, 4'h0);

    // 6: async reset while waiting for R
    req_ren = 1'b1; req_addr = 32'h8000_0200; req_cached = 1'b1; arready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; arready = 1'b0; req_ren = 1'b0;
    @(negedge clk); check("pre_rst_rready", {31'b0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_inst", inst, 32'h0);
    check("async_rst_ctrl", {28'b0, inst_valid, arvalid, rready, stall}, 32'h0);
    check("async_rst_araddr", araddr, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    do_fetch(32'h0000_0040, 1'b1, 0, 32'h0000_0040, 2'b00, 32'h0000_0040, 4'hF);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
